// File: rtl/muldiv_sequencer_if.sv
// Handshake and operand bus between the EX stage and the multiply/divide sequencer.
interface muldiv_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             start_i;
   logic             kill_i;
   logic [2:0]       funct3_i;
   logic [WIDTH-1:0] data1_i;
   logic [WIDTH-1:0] data2_i;
   logic [WIDTH-1:0] result_o;
   logic             busy_o;
   logic             done_o;

   modport master (
      output start_i, kill_i, funct3_i, data1_i, data2_i,
      input  result_o, busy_o, done_o
   );

   modport slave (
      input  start_i, kill_i, funct3_i, data1_i, data2_i,
      output result_o, busy_o, done_o
   );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer: radix-2 shift-add multiplier and
// restoring divider sharing one 2*WIDTH accumulator, one iteration per cycle.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for START; operands are sampled on accept
// S_CALC   | one multiply/divide iteration per cycle, WIDTH cycles
// S_FINISH | RESULT valid, DONE pulses (unless KILL), back to S_IDLE
module muldiv_sequencer #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input logic               clk_i,
   input logic               rst_i,
   muldiv_sequencer_if.slave bus
);
   localparam int W = WIDTH;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(W - 1);
   localparam logic [W-1:0]     MIN_NEG   = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CALC   = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]     op_q, op_d;
   logic           neg_q, neg_d;
   logic [W-1:0]   opb_q, opb_d;
   logic [2*W-1:0] acc_q, acc_d;
   logic [W-1:0]   result_q, result_d;

   logic           accept;
   logic [2:0]     f3;
   logic           sgn1_op, sgn2_op, s1, s2, neg_in;
   logic           div_zero, div_ovf, special;
   logic [W-1:0]   abs1, abs2, special_res;

   logic [W:0]     mul_sum, div_rem, div_trial;
   logic [2*W-1:0] mul_next, div_next, acc_step, prod_s;
   logic [W-1:0]   quo_s, rem_s, calc_res;
   logic           busy, done;

   // Operand decode at accept: magnitudes, result sign and the no-iteration cases.
   assign f3      = bus.funct3_i;
   assign accept  = (state_q == S_IDLE) && bus.start_i && !bus.kill_i;
   assign sgn1_op = (f3 == 3'b001) || (f3 == 3'b010) || (f3[2] && !f3[0]);
   assign sgn2_op = (f3 == 3'b001) || (f3[2] && !f3[0]);
   assign s1      = sgn1_op && bus.data1_i[W-1];
   assign s2      = sgn2_op && bus.data2_i[W-1];
   assign abs1    = s1 ? -bus.data1_i : bus.data1_i;
   assign abs2    = s2 ? -bus.data2_i : bus.data2_i;
   // Remainder follows the dividend; everything else is the XOR of the signs.
   assign neg_in  = (f3 == 3'b110) ? s1 : (s1 ^ s2);

   assign div_zero = f3[2] && (bus.data2_i == '0);
   assign div_ovf  = f3[2] && !f3[0] && (bus.data1_i == MIN_NEG) && (bus.data2_i == '1);
   assign special  = div_zero || div_ovf;
   assign special_res = div_zero ? (f3[1] ? bus.data1_i : '1)
                                 : (f3[1] ? '0 : MIN_NEG);

   // One iteration of the shared datapath plus sign fix-up and result select.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, opb_q};
      mul_next  = acc_q[0] ? {mul_sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};
      // Partial remainder keeps its top bit so the shifted value never overflows.
      div_rem   = acc_q[2*W-1:W-1];
      div_trial = div_rem - {1'b0, opb_q};
      div_next  = div_trial[W] ? {acc_q[2*W-2:0], 1'b0}
                               : {div_trial[W-1:0], acc_q[W-2:0], 1'b1};
      acc_step  = op_q[2] ? div_next : mul_next;
      prod_s    = neg_q ? -acc_step : acc_step;
      quo_s     = neg_q ? -acc_step[W-1:0] : acc_step[W-1:0];
      rem_s     = neg_q ? -acc_step[2*W-1:W] : acc_step[2*W-1:W];
      case (op_q)
         3'b000:                 calc_res = prod_s[W-1:0];
         3'b001, 3'b010, 3'b011: calc_res = prod_s[2*W-1:W];
         3'b100, 3'b101:         calc_res = quo_s;
         default:                calc_res = rem_s;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; KILL aborts CALC and beats START in IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (accept) state_d = special ? S_FINISH : S_CALC;
         S_CALC: begin
            if (bus.kill_i)              state_d = S_IDLE;
            else if (cnt_q == LAST_ITER) state_d = S_FINISH;
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Status outputs.
   always_comb begin
      busy = (state_q != S_IDLE);
      done = (state_q == S_FINISH) && !bus.kill_i;
   end

   // Datapath next values: load on accept, iterate in CALC, capture result on exit.
   always_comb begin
      op_d     = op_q;
      neg_d    = neg_q;
      opb_d    = opb_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d  = f3;
               neg_d = neg_in;
               opb_d = abs2;
               acc_d = {{W{1'b0}}, abs1};
               cnt_d = '0;
               if (special) result_d = special_res;
            end
         end
         S_CALC: begin
            if (!bus.kill_i) begin
               acc_d = acc_step;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_ITER) result_d = calc_res;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         op_q     <= '0;
         neg_q    <= 1'b0;
         opb_q    <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         op_q     <= op_d;
         neg_q    <= neg_d;
         opb_q    <= opb_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   assign bus.result_o = result_q;
   assign bus.busy_o   = busy;
   assign bus.done_o   = done;
endmodule
